// File: rtl/bnn_pkg.sv
// -----------------------------------------------------------------------------
// bnn_pkg
// Shared constants and types for the BNN output-layer class scheduler.
//   IMG_BITS     flattened image width
//   CHUNK_W      bits compared per cycle (weight ROM word width)
//   NUM_CLASSES  number of output classes
//   CLASS_W      class index / result width
//   derived      NUM_CHUNKS, SCORE_W, ADDR_W, CHUNK_IDX_W, POP_W
//   sched_state_t  scheduler FSM states
// -----------------------------------------------------------------------------
package bnn_pkg;

   localparam int IMG_BITS    = 904;
   localparam int CHUNK_W     = 8;
   localparam int NUM_CLASSES = 10;
   localparam int CLASS_W     = 4;

   localparam int NUM_CHUNKS  = (IMG_BITS + CHUNK_W - 1) / CHUNK_W;
   localparam int SCORE_W     = $clog2(IMG_BITS + 1);
   localparam int ADDR_W      = $clog2(NUM_CLASSES * NUM_CHUNKS);
   // Chunk counter runs one past the last chunk on the final FETCH cycle.
   localparam int CHUNK_IDX_W = $clog2(NUM_CHUNKS + 1);
   localparam int POP_W       = $clog2(CHUNK_W + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      DRAIN = 3'd2,
      CMP   = 3'd3,
      DONE  = 3'd4
   } sched_state_t;

endpackage

// File: rtl/xnor_popcount.sv
// -----------------------------------------------------------------------------
// xnor_popcount
// Combinational XNOR-popcount of one image chunk against one weight word.
// Masked-off bits (padding beyond the image) never contribute.
//   img_chunk_i  in   W          image bits of the chunk
//   w_data_i     in   W          weight ROM word
//   mask_i       in   W          1 = bit is part of the image
//   count_o      out  POP_W      number of matching, unmasked bits
// -----------------------------------------------------------------------------
module xnor_popcount #(
   parameter int W     = 8,
   parameter int POP_W = $clog2(W + 1)
) (
   input  logic [W-1:0]     img_chunk_i,
   input  logic [W-1:0]     w_data_i,
   input  logic [W-1:0]     mask_i,
   output logic [POP_W-1:0] count_o
);

   logic [W-1:0] match;

   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : g_match
         assign match[gi] = ~(img_chunk_i[gi] ^ w_data_i[gi]) & mask_i[gi];
      end
   endgenerate

   always_comb begin
      count_o = '0;
      for (int i = 0; i < W; i++) begin
         count_o = count_o + POP_W'(match[i]);
      end
   end

endmodule

// File: rtl/bnn_class_scheduler.sv
// -----------------------------------------------------------------------------
// bnn_class_scheduler
// Runs BNN output-layer inference over one shared XNOR-popcount datapath:
// for every class it streams weight-ROM chunks against the image, sums the
// popcounts and keeps the running argmax; the winner is reported with a
// one-cycle result_ready pulse.
//   clk           in   1          system clock
//   rst_n         in   1          asynchronous active-low reset
//   start         in   1          begin inference (sampled only in IDLE)
//   clear         in   1          synchronous abort/clear, beats start
//   img_in        in   IMG_BITS   image, stable while busy
//   w_addr        out  ADDR_W     weight ROM address = class*NUM_CHUNKS+chunk
//   w_rd_en       out  1          weight ROM read strobe
//   w_data        in   CHUNK_W    ROM data, one cycle after w_rd_en
//   busy          out  1          inference in progress
//   result_ready  out  1          one-cycle pulse, result/score valid
//   result_out    out  CLASS_W    argmax class (held)
//   score_out     out  SCORE_W    winning score (held)
// -----------------------------------------------------------------------------
module bnn_class_scheduler
   import bnn_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                clear,
   input  logic [IMG_BITS-1:0] img_in,
   output logic [ADDR_W-1:0]   w_addr,
   output logic                w_rd_en,
   input  logic [CHUNK_W-1:0]  w_data,
   output logic                busy,
   output logic                result_ready,
   output logic [CLASS_W-1:0]  result_out,
   output logic [SCORE_W-1:0]  score_out
);

   sched_state_t state_q, state_d;

   logic [CLASS_W-1:0]     class_q, class_d;
   logic [CHUNK_IDX_W-1:0] chunk_q, chunk_d;
   logic [CHUNK_IDX_W-1:0] pend_chunk_q, pend_chunk_d;
   logic [ADDR_W-1:0]      base_q, base_d;
   logic [ADDR_W-1:0]      last_addr_q, last_addr_d;
   logic [SCORE_W-1:0]     acc_q, acc_d;
   logic [SCORE_W-1:0]     best_q, best_d;
   logic [CLASS_W-1:0]     best_idx_q, best_idx_d;
   logic [CLASS_W-1:0]     result_q, result_d;
   logic [SCORE_W-1:0]     score_q, score_d;
   logic                   valid_q, valid_d;

   logic [ADDR_W-1:0]      cur_addr;
   logic                   last_chunk;
   logic                   last_class;
   logic                   take_new;

   logic [NUM_CHUNKS-1:0][CHUNK_W-1:0] img_chunks;
   logic [NUM_CHUNKS-1:0][CHUNK_W-1:0] mask_chunks;
   logic [CHUNK_W-1:0]                 img_chunk;
   logic [CHUNK_W-1:0]                 chunk_mask;
   logic [POP_W-1:0]                   pop;

   // ---------------------------------------------------------------------
   // Image slicing: chunk gi bit bi is image bit gi*CHUNK_W+bi. Bits past
   // the end of the image read as 0 and are masked out of the popcount.
   // ---------------------------------------------------------------------
   genvar gi, bi;
   generate
      for (gi = 0; gi < NUM_CHUNKS; gi++) begin : g_chunk
         for (bi = 0; bi < CHUNK_W; bi++) begin : g_bit
            if (gi * CHUNK_W + bi < IMG_BITS) begin : g_in
               assign img_chunks[gi][bi]  = img_in[gi*CHUNK_W+bi];
               assign mask_chunks[gi][bi] = 1'b1;
            end else begin : g_pad
               assign img_chunks[gi][bi]  = 1'b0;
               assign mask_chunks[gi][bi] = 1'b0;
            end
         end
      end
   endgenerate

   // The ROM answers one cycle late, so compare against the chunk issued
   // in the previous cycle, not the one being issued now.
   assign img_chunk  = img_chunks[pend_chunk_q];
   assign chunk_mask = mask_chunks[pend_chunk_q];

   xnor_popcount #(
      .W     (CHUNK_W),
      .POP_W (POP_W)
   ) u_xnor_popcount (
      .img_chunk_i (img_chunk),
      .w_data_i    (w_data),
      .mask_i      (chunk_mask),
      .count_o     (pop)
   );

   // base_q tracks class*NUM_CHUNKS incrementally, avoiding a multiplier.
   assign cur_addr   = base_q + ADDR_W'(chunk_q);
   assign last_chunk = (chunk_q == CHUNK_IDX_W'(NUM_CHUNKS - 1));
   assign last_class = (class_q == CLASS_W'(NUM_CLASSES - 1));
   // Strict > keeps the lower index on ties; class 0 always seeds best.
   assign take_new   = (class_q == '0) || (acc_q > best_q);

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   if (last_chunk) state_d = DRAIN;
            DRAIN:   state_d = CMP;
            CMP:     state_d = last_class ? DONE : FETCH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------
   always_comb begin
      w_rd_en      = 1'b0;
      busy         = 1'b0;
      result_ready = 1'b0;
      case (state_q)
         FETCH:   begin w_rd_en = 1'b1; busy = 1'b1; end
         DRAIN:   busy = 1'b1;
         CMP:     busy = 1'b1;
         DONE:    result_ready = 1'b1;
         default: ;
      endcase
   end

   // Address is live while fetching and otherwise holds the last issued one.
   assign w_addr     = w_rd_en ? cur_addr : last_addr_q;
   assign result_out = result_q;
   assign score_out  = score_q;

   // ---------------------------------------------------------------------
   // Datapath: counters, accumulator, argmax and result registers
   // ---------------------------------------------------------------------
   always_comb begin
      class_d      = class_q;
      chunk_d      = chunk_q;
      pend_chunk_d = pend_chunk_q;
      base_d       = base_q;
      last_addr_d  = last_addr_q;
      best_d       = best_q;
      best_idx_d   = best_idx_q;
      result_d     = result_q;
      score_d      = score_q;
      valid_d      = 1'b0;
      // Any cycle after a read strobe folds the returned word in.
      acc_d        = valid_q ? (acc_q + SCORE_W'(pop)) : acc_q;

      if (clear) begin
         // Abort: discard in-flight ROM data and drop the held result.
         class_d      = '0;
         chunk_d      = '0;
         pend_chunk_d = '0;
         base_d       = '0;
         last_addr_d  = '0;
         acc_d        = '0;
         best_d       = '0;
         best_idx_d   = '0;
         result_d     = '0;
         score_d      = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  class_d    = '0;
                  chunk_d    = '0;
                  base_d     = '0;
                  acc_d      = '0;
                  best_d     = '0;
                  best_idx_d = '0;
                  result_d   = '0;
                  score_d    = '0;
               end
            end
            FETCH: begin
               valid_d      = 1'b1;
               pend_chunk_d = chunk_q;
               chunk_d      = chunk_q + CHUNK_IDX_W'(1);
               last_addr_d  = cur_addr;
            end
            CMP: begin
               if (take_new) begin
                  best_d     = acc_q;
                  best_idx_d = class_q;
               end
               if (last_class) begin
                  // Publish now so the values are valid alongside the pulse.
                  result_d = take_new ? class_q : best_idx_q;
                  score_d  = take_new ? acc_q : best_q;
               end else begin
                  class_d = class_q + CLASS_W'(1);
                  base_d  = base_q + ADDR_W'(NUM_CHUNKS);
                  chunk_d = '0;
                  acc_d   = '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         class_q      <= '0;
         chunk_q      <= '0;
         pend_chunk_q <= '0;
         base_q       <= '0;
         last_addr_q  <= '0;
         acc_q        <= '0;
         best_q       <= '0;
         best_idx_q   <= '0;
         result_q     <= '0;
         score_q      <= '0;
         valid_q      <= 1'b0;
      end else begin
         class_q      <= class_d;
         chunk_q      <= chunk_d;
         pend_chunk_q <= pend_chunk_d;
         base_q       <= base_d;
         last_addr_q  <= last_addr_d;
         acc_q        <= acc_d;
         best_q       <= best_d;
         best_idx_q   <= best_idx_d;
         result_q     <= result_d;
         score_q      <= score_d;
         valid_q      <= valid_d;
      end
   end

endmodule

// File: tb/tb_bnn_class_scheduler.sv
// -----------------------------------------------------------------------------
// tb_bnn_class_scheduler
// Directed bench for bnn_class_scheduler with a 1-cycle-latency ROM model and
// a result scoreboard. Expected class/score pairs are pushed when a run is
// started and popped when result_ready pulses.
// -----------------------------------------------------------------------------
module tb_bnn_class_scheduler;

   localparam int IMG      = 904;
   localparam int NCHUNK   = 113;
   localparam int NCLASS   = 10;
   localparam int ROM_SZ   = NCLASS * NCHUNK;
   localparam int LATENCY  = 1151;

   logic         clk    = 1'b0;
   logic         rst_n  = 1'b0;
   logic         start  = 1'b0;
   logic         clear  = 1'b0;
   logic [903:0] img_in = '0;
   logic [10:0]  w_addr;
   logic         w_rd_en;
   logic [7:0]   w_data = '0;
   logic         busy;
   logic         result_ready;
   logic [3:0]   result_out;
   logic [9:0]   score_out;

   always #5 clk = ~clk;

   bnn_class_scheduler dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .clear        (clear),
      .img_in       (img_in),
      .w_addr       (w_addr),
      .w_rd_en      (w_rd_en),
      .w_data       (w_data),
      .busy         (busy),
      .result_ready (result_ready),
      .result_out   (result_out),
      .score_out    (score_out)
   );

   // Behavioural weight ROM, one cycle read latency.
   logic [7:0] rom [0:ROM_SZ-1];
   always @(posedge clk) begin
      if (w_rd_en) w_data <= rom[w_addr];
   end

   typedef struct {
      int cls;
      int score;
   } exp_t;
   exp_t sb[$];

   int checks    = 0;
   int failures  = 0;
   int cyc_cnt   = 0;
   int start_cyc = 0;
   int ready_cyc = 0;
   int pulses    = 0;
   int addr_next = 0;
   bit addr_bad  = 1'b0;
   int tgt [NCLASS];

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Monitor: address ordering and result scoreboard.
   always @(negedge clk) begin
      if (rst_n && w_rd_en) begin
         if (int'(w_addr) != addr_next) addr_bad = 1'b1;
         addr_next = addr_next + 1;
      end
      if (result_ready) begin
         pulses++;
         ready_cyc = cyc_cnt;
         $display("result: class=%0d score=%0d cycle=%0d", result_out, score_out, cyc_cnt - start_cyc);
         check("busy_low_at_ready", 32'(busy), 0);
         check("addr_count", addr_next, ROM_SZ);
         check("addr_order", 32'(addr_bad), 0);
         check("expectation_pending", 32'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("result_out", 32'(result_out), e.cls);
            check("score_out", 32'(score_out), e.score);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input bit expect_result, input int cls, input int score);
      exp_t e;
      if (expect_result) begin
         e.cls   = cls;
         e.score = score;
         sb.push_back(e);
      end
      addr_next = 0;
      addr_bad  = 1'b0;
      pulses    = 0;
      start     = 1'b1;
      start_cyc = cyc_cnt;
      tick();
      start = 1'b0;
   endtask

   task automatic goto_cycle(input int n);
      int guard = 0;
      while ((cyc_cnt - start_cyc) < n && guard < 3000) begin
         tick();
         guard++;
      end
   endtask

   task automatic wait_result(input string tag);
      int n = 0;
      while (pulses == 0 && n < 2000) begin
         tick();
         n++;
      end
      check({tag, "_pulse_seen"}, 32'(pulses > 0), 1);
      check({tag, "_latency"}, ready_cyc - start_cyc, LATENCY);
      repeat (4) tick();
      check({tag, "_one_pulse"}, pulses, 1);
   endtask

   // Class c's weights equal the image with the first IMG-tgt[c] bits flipped,
   // so class c scores exactly tgt[c].
   task automatic build_rom();
      for (int c = 0; c < NCLASS; c++) begin
         for (int i = 0; i < IMG; i++) begin
            rom[c*NCHUNK + i/8][i%8] = img_in[i] ^ (i < (IMG - tgt[c]));
         end
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_w_rd_en"}, 32'(w_rd_en), 0);
      check({tag, "_result_ready"}, 32'(result_ready), 0);
      check({tag, "_result_out"}, 32'(result_out), 0);
      check({tag, "_score_out"}, 32'(score_out), 0);
   endtask

   initial begin
      for (int a = 0; a < ROM_SZ; a++) rom[a] = 8'h00;

      // Reset state
      rst_n = 1'b0;
      repeat (3) tick();
      check_idle_outputs("reset");
      check("reset_w_addr", 32'(w_addr), 0);
      rst_n = 1'b1;
      tick();

      // start and clear together: clear wins
      start = 1'b1;
      clear = 1'b1;
      tick();
      start = 1'b0;
      clear = 1'b0;
      check("start_clear_busy", 32'(busy), 0);
      tick();
      check("start_clear_busy_later", 32'(busy), 0);

      // Scenario 1: image all ones, ROM all zeros -> all scores 0, class 0 wins
      img_in = '1;
      start_run(1'b1, 0, 0);
      wait_result("s1");

      // Scenario 2: class 7 matches the image, every other class is its inverse
      for (int i = 0; i < IMG; i++) img_in[i] = 1'($urandom_range(0, 1));
      for (int c = 0; c < NCLASS; c++) tgt[c] = 0;
      tgt[7] = IMG;
      build_rom();
      start_run(1'b1, 7, 904);
      wait_result("s2");
      check("s2_held_result", 32'(result_out), 7);
      check("s2_held_score", 32'(score_out), 904);

      // Scenario 5: start pulses while busy are ignored
      start_run(1'b1, 7, 904);
      goto_cycle(10);
      start = 1'b1;
      tick();
      start = 1'b0;
      goto_cycle(900);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_result("s5");

      // Scenario 4: clear mid-run, then a full rerun
      start_run(1'b0, 0, 0);
      goto_cycle(500);
      check("s4_busy_before_clear", 32'(busy), 1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check_idle_outputs("s4_after_clear");
      repeat (30) tick();
      check("s4_no_pulse", pulses, 0);
      start_run(1'b1, 7, 904);
      wait_result("s4_rerun");

      // Scenario 6: asynchronous reset mid-run
      start_run(1'b0, 0, 0);
      goto_cycle(300);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle_outputs("s6_in_reset");
      check("s6_w_addr", 32'(w_addr), 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("s6_busy_after_release", 32'(busy), 0);
      check("s6_no_pulse", pulses, 0);
      start_run(1'b1, 7, 904);
      wait_result("s6");

      // Scenario 3: classes 3 and 5 tie at 600, lower index wins
      for (int c = 0; c < NCLASS; c++) tgt[c] = 100 + 10 * c;
      tgt[3] = 600;
      tgt[5] = 600;
      build_rom();
      start_run(1'b1, 3, 600);
      wait_result("s3");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
